// File: rtl/stb_dcache_drain_controller_pkg.sv
// Shared store-buffer types: drain FSM states and the packed entry layout
// also used by store_buffer_datapath.
package stb_pkg;

  localparam int STB_ADDR_W = 32;
  localparam int STB_DATA_W = 32;

  typedef enum logic [1:0] {DR_IDLE, DR_REQ, DR_POP} drain_state_t;

  typedef struct packed {
    logic [STB_ADDR_W-1:0]   addr;
    logic [STB_DATA_W-1:0]   data;
    logic [STB_DATA_W/8-1:0] sel;
  } stb_entry_t;

endpackage

// File: rtl/stb_dcache_drain_controller_if.sv
// Store-buffer to dcache write-port handshake bundle.
interface stb_drain_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  stb2dcache_req;
  logic                  stb2dcache_w_en;
  logic [ADDR_W-1:0]     stb2dcache_addr;
  logic [DATA_W-1:0]     stb2dcache_data;
  logic [DATA_W/8-1:0]   stb2dcache_sel;
  logic                  dcache2stb_ack;

  modport master (
    output stb2dcache_req,
    output stb2dcache_w_en,
    output stb2dcache_addr,
    output stb2dcache_data,
    output stb2dcache_sel,
    input  dcache2stb_ack
  );

  modport slave (
    input  stb2dcache_req,
    input  stb2dcache_w_en,
    input  stb2dcache_addr,
    input  stb2dcache_data,
    input  stb2dcache_sel,
    output dcache2stb_ack
  );
endinterface

// File: rtl/stb_dcache_drain_controller_watchdog.sv
// Request watchdog: counts cycles a request waits for ack and pulses expire
// on the LIMIT-th unacknowledged cycle.
module stb_drain_watchdog #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expire
);
  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_reg;

  assign expire = run && !clear && (cnt_reg == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || expire || !run) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end
endmodule

// File: rtl/stb_dcache_drain_controller.sv
// Drains committed stores from the store buffer head to the dcache write port
// and answers LSU flush requests. STB_DRAIN_TIMEOUT_EN adds a retrying watchdog.
module stb_dcache_drain_controller
  import stb_pkg::*;
#(
  parameter int ADDR_W         = STB_ADDR_W,
  parameter int DATA_W         = STB_DATA_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stb_empty,
  input  logic [ADDR_W-1:0]   stb_rd_addr,
  input  logic [DATA_W-1:0]   stb_rd_data,
  input  logic [DATA_W/8-1:0] stb_rd_sel,
  output logic                stb_rd_en,
  stb_drain_if.master         dc,
  input  logic                lsummu2stb_flush_req,
  output logic                stb2lsummu_flush_done,
  output logic                stb_drain_busy
`ifdef STB_DRAIN_TIMEOUT_EN
  ,
  output logic                stb_drain_timeout_err
`endif
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  drain_state_t        state_reg, state_next;
  logic                req_reg, req_next;
  logic                rd_en_reg, rd_en_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic [DATA_W/8-1:0] sel_reg, sel_next;
  logic                pending_reg, pending_next;
  logic                done_reg, done_next;
  logic                busy_reg, busy_next;
  logic                flush_fire;
  logic                expire;

`ifdef STB_DRAIN_TIMEOUT_EN
  logic err_reg;

  stb_drain_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst_n),
    .run    ((state_reg == DR_REQ) && req_reg),
    .clear  (dc.dcache2stb_ack),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      err_reg <= 1'b0;
    end else if (expire) begin
      err_reg <= 1'b1;
    end
  end

  assign stb_drain_timeout_err = err_reg;
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    rd_en_next = 1'b0;
    addr_next  = addr_reg;
    data_next  = data_reg;
    sel_next   = sel_reg;

    case (state_reg)
      DR_IDLE: begin
        if (!stb_empty) begin
          addr_next  = stb_rd_addr;
          data_next  = stb_rd_data;
          sel_next   = stb_rd_sel;
          req_next   = 1'b1;
          state_next = DR_REQ;
        end
      end
      DR_REQ: begin
        // req low inside DR_REQ is the one-cycle gap before a watchdog retry
        if (!req_reg) begin
          req_next = 1'b1;
        end else if (dc.dcache2stb_ack) begin
          req_next   = 1'b0;
          rd_en_next = 1'b1;
          state_next = DR_POP;
        end else if (expire) begin
          req_next = 1'b0;
        end
      end
      DR_POP: begin
        state_next = DR_IDLE;
      end
      default: begin
        req_next   = 1'b0;
        state_next = DR_IDLE;
      end
    endcase

    // A request seen at the completing edge is answered by the same pulse
    // only if nothing was pending; otherwise it stays queued for another pulse.
    flush_fire   = (pending_reg || lsummu2stb_flush_req) && (state_reg == DR_IDLE) && stb_empty;
    done_next    = flush_fire;
    pending_next = flush_fire ? (pending_reg && lsummu2stb_flush_req)
                              : (pending_reg || lsummu2stb_flush_req);
    busy_next    = (state_next != DR_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg   <= DR_IDLE;
      req_reg     <= 1'b0;
      rd_en_reg   <= 1'b0;
      addr_reg    <= '0;
      data_reg    <= '0;
      sel_reg     <= '0;
      pending_reg <= 1'b0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      req_reg     <= req_next;
      rd_en_reg   <= rd_en_next;
      addr_reg    <= addr_next;
      data_reg    <= data_next;
      sel_reg     <= sel_next;
      pending_reg <= pending_next;
      done_reg    <= done_next;
      busy_reg    <= busy_next;
    end
  end

  assign stb_rd_en             = rd_en_reg;
  assign dc.stb2dcache_req     = req_reg;
  assign dc.stb2dcache_w_en    = req_reg;
  assign dc.stb2dcache_addr    = addr_reg;
  assign dc.stb2dcache_data    = data_reg;
  assign dc.stb2dcache_sel     = sel_reg;
  assign stb2lsummu_flush_done = done_reg;
  assign stb_drain_busy        = busy_reg;

endmodule

// File: tb/tb_stb_dcache_drain_controller.sv
// Self-checking bench: store-buffer and dcache models around the drain
// controller, with a scoreboard of expected dcache writes.
module tb_stb_dcache_drain_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb_empty;
  logic [31:0] stb_rd_addr;
  logic [31:0] stb_rd_data;
  logic [3:0]  stb_rd_sel;
  logic        stb_rd_en;
  logic        flush_req;
  logic        flush_done;
  logic        busy;
`ifdef STB_DRAIN_TIMEOUT_EN
  logic        timeout_err;
`endif

  stb_drain_if #(.ADDR_W(32), .DATA_W(32)) dc ();

  stb_dcache_drain_controller #(
    .ADDR_W         (32),
    .DATA_W         (32),
`ifdef STB_DRAIN_TIMEOUT_EN
    .TIMEOUT_CYCLES (8)
`else
    .TIMEOUT_CYCLES (256)
`endif
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .stb_empty             (stb_empty),
    .stb_rd_addr           (stb_rd_addr),
    .stb_rd_data           (stb_rd_data),
    .stb_rd_sel            (stb_rd_sel),
    .stb_rd_en             (stb_rd_en),
    .dc                    (dc.master),
    .lsummu2stb_flush_req  (flush_req),
    .stb2lsummu_flush_done (flush_done),
    .stb_drain_busy        (busy)
`ifdef STB_DRAIN_TIMEOUT_EN
    ,
    .stb_drain_timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [67:0] fifo[$];
  logic [67:0] exp_q[$];
  int          rise_q[$];
  int          n_req = 0, n_pop = 0, n_done = 0;
  int          last_rd_cyc = -1, last_done_cyc = -1;
  int          req_age = 0;
  int          ack_lat = 0;
  bit          ack_on = 1'b1;
  bit          spur = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [67:0] payload();
    return {dc.stb2dcache_addr, dc.stb2dcache_data, dc.stb2dcache_sel};
  endfunction

  task automatic update_head();
    stb_empty = (fifo.size() == 0);
    if (fifo.size() > 0) {stb_rd_addr, stb_rd_data, stb_rd_sel} = fifo[0];
    else {stb_rd_addr, stb_rd_data, stb_rd_sel} = '0;
  endtask

  task automatic push_entry(input logic [67:0] e);
    fifo.push_back(e);
    exp_q.push_back(e);
    update_head();
  endtask

  // One clock: score accepted writes, advance the models, redrive inputs.
  task automatic step();
    logic        acc, rd_was, req_was;
    logic [67:0] pl_was, e;
    acc     = dc.stb2dcache_req && dc.dcache2stb_ack;
    rd_was  = stb_rd_en;
    req_was = dc.stb2dcache_req;
    pl_was  = payload();
    if (acc) begin
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("payload", pl_was, e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rd_was && fifo.size() > 0) fifo.delete(0);
    if (stb_rd_en || acc) check("rd_en", stb_rd_en, acc);
    if (dc.stb2dcache_w_en !== dc.stb2dcache_req) check("w_en", dc.stb2dcache_w_en, dc.stb2dcache_req);
    if (req_was && dc.stb2dcache_req && !rst_n) check("hold", payload(), pl_was);
    if (dc.stb2dcache_req) begin
      n_req++;
      if (!req_was) rise_q.push_back(cyc);
    end
    if (stb_rd_en) begin
      n_pop++;
      last_rd_cyc = cyc;
    end
    if (flush_done) begin
      n_done++;
      last_done_cyc = cyc;
    end
    update_head();
    if (dc.stb2dcache_req) req_age++;
    else req_age = 0;
    dc.dcache2stb_ack = spur || (ack_on && dc.stb2dcache_req && (req_age > ack_lat));
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      step();
      ok = (fifo.size() == 0) && (exp_q.size() == 0) && !busy;
    end
    check(tag, ok, 1);
  endtask

  initial begin
    int          p, n_req0, n_pop0, d0;
    logic [67:0] e;
    logic [31:0] a, d;
    logic [3:0]  s;

    rst_n = 1'b1;
    flush_req = 1'b0;
    dc.dcache2stb_ack = 1'b0;
    update_head();
    repeat (3) step();
    check("rst_outputs", {stb_rd_en, dc.stb2dcache_req, dc.stb2dcache_w_en, payload(), flush_done, busy}, 0);
`ifdef STB_DRAIN_TIMEOUT_EN
    check("rst_err", timeout_err, 0);
`endif
    rst_n = 1'b0;
    step();
    check("idle_after_rst", {dc.stb2dcache_req, stb_rd_en, flush_done, busy}, 0);

    // Single store, ack two cycles after req
    ack_lat = 2; p = cyc; n_req0 = n_req; n_pop0 = n_pop;
    push_entry({32'h0000_1000, 32'hDEAD_BEEF, 4'hF});
    repeat (4) step();
    check("t1_first_req", rise_q[$], p + 1);
    check("t1_req_cycles", n_req - n_req0, 3);
    check("t1_rd_en_cyc", last_rd_cyc, p + 4);
    check("t1_busy_pop", busy, 1);
    step();
    check("t1_busy_idle", busy, 0);
    check("t1_pops", n_pop - n_pop0, 1);

    // Three queued entries, immediate ack
    ack_lat = 0; p = cyc; n_pop0 = n_pop; rise_q.delete();
    for (int i = 0; i < 3; i++) begin
      a = 32'h2000 + 32'(i * 4);
      d = $urandom();
      s = 4'(i + 1);
      push_entry({a, d, s});
    end
    repeat (12) step();
    check("t2_n_req", rise_q.size(), 3);
    for (int i = 0; i < 3 && i < rise_q.size(); i++) check("t2_req_cyc", rise_q[i], p + 1 + 3 * i);
    check("t2_pops", n_pop - n_pop0, 3);
    check("t2_empty", stb_empty, 1);
    check("t2_sb_left", exp_q.size(), 0);

    // Flush while empty and idle
    p = cyc; d0 = n_done;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    check("t3_done_pulse", flush_done, 1);
    step();
    check("t3_done_low", flush_done, 0);
    check("t3_done_cnt", n_done - d0, 1);
    check("t3_done_cyc", last_done_cyc, p + 1);

    // Flush with two entries queued
    ack_lat = 1; p = cyc; d0 = n_done;
    push_entry({32'h0000_3000, 32'h1111_2222, 4'h3});
    push_entry({32'h0000_3004, 32'h3333_4444, 4'hC});
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    for (int k = 0; k < 30 && n_done == d0; k++) step();
    check("t3b_done_cyc", last_done_cyc, p + 9);
    check("t3b_after_pop", last_done_cyc - last_rd_cyc, 2);
    repeat (3) step();
    check("t3b_done_cnt", n_done - d0, 1);
    check("t3b_sb_left", exp_q.size(), 0);

    // Reset while a request waits for ack
    ack_on = 1'b0; n_pop0 = n_pop;
    e = {32'h0000_4000, 32'hCAFE_F00D, 4'h5};
    push_entry(e);
    repeat (3) step();
    check("t4_req_up", dc.stb2dcache_req, 1);
    rst_n = 1'b1;
    step();
    check("t4_rst_outputs", {stb_rd_en, dc.stb2dcache_req, dc.stb2dcache_w_en, payload(), flush_done, busy}, 0);
    rst_n = 1'b0;
    check("t4_no_pop", n_pop - n_pop0, 0);
    ack_on = 1'b1;
    wait_idle("t4_drain");
    check("t4_reissue_pop", n_pop - n_pop0, 1);

    // Spurious ack while idle
    n_pop0 = n_pop; spur = 1'b1;
    dc.dcache2stb_ack = 1'b1;
    repeat (3) step();
    check("t5_busy", busy, 0);
    check("t5_req", dc.stb2dcache_req, 0);
    check("t5_pops", n_pop - n_pop0, 0);
    spur = 1'b0;
    dc.dcache2stb_ack = 1'b0;
    step();

`ifdef STB_DRAIN_TIMEOUT_EN
    // Watchdog retry after 8 unacknowledged cycles
    ack_on = 1'b0; ack_lat = 0; p = cyc; n_pop0 = n_pop;
    e = {32'h0000_5000, 32'h0BAD_C0DE, 4'h9};
    push_entry(e);
    repeat (8) step();
    check("t7_req_8", dc.stb2dcache_req, 1);
    check("t7_err_pre", timeout_err, 0);
    step();
    check("t7_req_gap", dc.stb2dcache_req, 0);
    check("t7_err_set", timeout_err, 1);
    step();
    check("t7_req_retry", dc.stb2dcache_req, 1);
    check("t7_retry_payload", payload(), e);
    check("t7_no_pop", n_pop - n_pop0, 0);
    ack_on = 1'b1;
    wait_idle("t7_drain");
    check("t7_pop", n_pop - n_pop0, 1);
    check("t7_err_sticky", timeout_err, 1);
`else
    // No ack at all: request is held indefinitely
    ack_on = 1'b0; n_req0 = n_req;
    e = {32'h0000_6000, 32'h5A5A_A5A5, 4'h6};
    push_entry(e);
    repeat (1000) step();
    check("t6_req_held", n_req - n_req0, 1000);
    check("t6_payload", payload(), e);
    check("t6_busy", busy, 1);
    ack_on = 1'b1;
    wait_idle("t6_drain");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
